mem_port_arbiter: RTL and testbench

- Shares the single memory port (cbus side) between instruction fetch (ibus side, IF stage) and data access (dbus side, MEM stage).
- Grants one requester at a time and latches its request into registered cbus outputs.
- Holds the grant until the cbus transaction completes, then returns a one-cycle data_ok to the winner.
- Sits between the pipeline core and the memory/cache interconnect. Includes a watchdog that flags a hung memory port.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch (i_*), data (d_*) and memory (c_*) sides of the memory-port arbiter.
// slave is the arbiter's view; master is the core/memory environment's view.
interface mem_port_arbiter_if;
  logic        i_valid;
  logic [63:0] i_addr;
  logic        i_data_ok;
  logic [63:0] i_rdata;

  logic        d_valid;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic [63:0] d_wdata;
  logic        d_data_ok;
  logic [63:0] d_rdata;

  logic        c_valid;
  logic        c_is_write;
  logic [2:0]  c_size;
  logic [63:0] c_addr;
  logic [7:0]  c_strobe;
  logic [63:0] c_wdata;
  logic        c_ready;
  logic        c_last;
  logic [63:0] c_rdata;

  modport slave (
    input  i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata,
    input  c_ready, c_last, c_rdata,
    output i_data_ok, i_rdata, d_data_ok, d_rdata,
    output c_valid, c_is_write, c_size, c_addr, c_strobe, c_wdata
  );

  modport master (
    output i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata,
    output c_ready, c_last, c_rdata,
    input  i_data_ok, i_rdata, d_data_ok, d_rdata,
    input  c_valid, c_is_write, c_size, c_addr, c_strobe, c_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, with a hung-port watchdog.
// Define ARB_RR_EN for round-robin arbitration; otherwise data always wins over fetch.
module mem_port_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic                timeout_err
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam bit               WD_EN     = (TIMEOUT != 0);

  state_t           r_state;
  state_t           w_nextState;
  logic             w_done;
  logic             w_grantD;
  logic             w_grantI;
  logic             w_iOk;
  logic             w_dOk;
  logic [CNT_W-1:0] r_wdCnt;
  logic [CNT_W-1:0] w_wdNext;
  logic             r_timeoutErr;

  logic             r_cValid;
  logic             r_cIsWrite;
  logic [2:0]       r_cSize;
  logic [63:0]      r_cAddr;
  logic [7:0]       r_cStrobe;
  logic [63:0]      r_cWdata;

  assign w_done = bus.c_ready & bus.c_last;

`ifdef ARB_RR_EN
  logic r_rrLastD;

  // Under contention the side that did not win last time gets the port.
  assign w_grantD = bus.d_valid & ~(bus.i_valid & r_rrLastD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rrLastD <= 1'b1;
    end else if (r_state == IDLE) begin
      if (w_grantD) begin
        r_rrLastD <= 1'b1;
      end else if (bus.i_valid) begin
        r_rrLastD <= 1'b0;
      end
    end
  end
`else
  assign w_grantD = bus.d_valid;
`endif

  assign w_grantI = bus.i_valid & ~w_grantD;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_grantD) begin
          w_nextState = SERVE_D;
        end else if (w_grantI) begin
          w_nextState = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (w_done) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The request is captured on the grant edge so the core may change its inputs freely afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cValid   <= 1'b0;
      r_cIsWrite <= 1'b0;
      r_cSize    <= 3'd0;
      r_cAddr    <= 64'd0;
      r_cStrobe  <= 8'd0;
      r_cWdata   <= 64'd0;
    end else if (r_state == IDLE) begin
      if (w_grantD) begin
        r_cValid   <= 1'b1;
        r_cIsWrite <= |bus.d_strobe;
        r_cSize    <= bus.d_size;
        r_cAddr    <= bus.d_addr;
        r_cStrobe  <= bus.d_strobe;
        r_cWdata   <= bus.d_wdata;
      end else if (w_grantI) begin
        r_cValid   <= 1'b1;
        r_cIsWrite <= 1'b0;
        r_cSize    <= 3'd3;
        r_cAddr    <= bus.i_addr;
        r_cStrobe  <= 8'd0;
        r_cWdata   <= 64'd0;
      end
    end else if (w_done) begin
      r_cValid   <= 1'b0;
      r_cIsWrite <= 1'b0;
      r_cSize    <= 3'd0;
      r_cAddr    <= 64'd0;
      r_cStrobe  <= 8'd0;
      r_cWdata   <= 64'd0;
    end
  end

  assign w_wdNext = r_wdCnt + 1'b1;

  // Watchdog only reports a stuck port; the transaction keeps waiting for completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdCnt      <= '0;
      r_timeoutErr <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_nextState != IDLE) begin
        r_wdCnt <= '0;
      end
    end else if (!w_done && (r_wdCnt != TIMEOUT_C)) begin
      r_wdCnt <= w_wdNext;
      if (WD_EN && (w_wdNext == TIMEOUT_C)) begin
        r_timeoutErr <= 1'b1;
      end
    end
  end

  assign w_iOk = (r_state == SERVE_I) & w_done;
  assign w_dOk = (r_state == SERVE_D) & w_done;

  assign bus.i_data_ok  = w_iOk;
  assign bus.i_rdata    = w_iOk ? bus.c_rdata : 64'd0;
  assign bus.d_data_ok  = w_dOk;
  assign bus.d_rdata    = w_dOk ? bus.c_rdata : 64'd0;
  assign bus.c_valid    = r_cValid;
  assign bus.c_is_write = r_cIsWrite;
  assign bus.c_size     = r_cSize;
  assign bus.c_addr     = r_cAddr;
  assign bus.c_strobe   = r_cStrobe;
  assign bus.c_wdata    = r_cWdata;
  assign busy           = (r_state != IDLE);
  assign timeout_err    = r_timeoutErr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for single-cycle behaviour plus
// hand-written sequences for contention, watchdog and asynchronous reset.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  logic busy;
  logic timeoutErr;
  int   nChecks = 0;
  int   nPass   = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        iValid;
    logic [63:0] iAddr;
    logic        dValid;
    logic [63:0] dAddr;
    logic [2:0]  dSize;
    logic [7:0]  dStrobe;
    logic [63:0] dWdata;
    logic        cReady;
    logic        cLast;
    logic [63:0] cRdata;
    logic        expIOk;
    logic        expDOk;
    logic [63:0] expRdata;
    logic        expCValid;
    logic        expCIsWrite;
    logic [2:0]  expCSize;
    logic [63:0] expCAddr;
    logic [7:0]  expCStrobe;
    logic [63:0] expCWdata;
    logic        expBusy;
  } vec_t;

  localparam logic [63:0] FA  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] SA  = 64'h0000_0000_8000_1008;
  localparam logic [63:0] SD  = 64'h0000_0000_DEAD_BEEF;
  localparam logic [63:0] DA  = 64'h0000_0000_0000_1000;
  localparam logic [63:0] Z64 = 64'h0;

  vec_t vecs[13];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.i_valid  = v.iValid;
    bus.i_addr   = v.iAddr;
    bus.d_valid  = v.dValid;
    bus.d_addr   = v.dAddr;
    bus.d_size   = v.dSize;
    bus.d_strobe = v.dStrobe;
    bus.d_wdata  = v.dWdata;
    bus.c_ready  = v.cReady;
    bus.c_last   = v.cLast;
    bus.c_rdata  = v.cRdata;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.i_valid  = 1'b0;
    bus.i_addr   = 64'h0;
    bus.d_valid  = 1'b0;
    bus.d_addr   = 64'h0;
    bus.d_size   = 3'd0;
    bus.d_strobe = 8'h0;
    bus.d_wdata  = 64'h0;
    bus.c_ready  = 1'b0;
    bus.c_last   = 1'b0;
    bus.c_rdata  = 64'h0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    #2;
    checkOutput("rst/cValid", 64'(bus.c_valid), 64'h0);
    checkOutput("rst/timeout", 64'(timeoutErr), 64'h0);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global time limit: got running, expected finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    logic [63:0] firstAddr;
    logic [63:0] secondAddr;
    logic        firstIsD;

    vecs[0]  = '{"fetch req",   1'b1, FA,  1'b0, Z64, 3'd0, 8'h00, Z64, 1'b0, 1'b0, Z64,
                 1'b0, 1'b0, Z64, 1'b1, 1'b0, 3'd3, FA,  8'h00, Z64, 1'b1};
    vecs[1]  = '{"fetch wait",  1'b1, FA,  1'b0, Z64, 3'd0, 8'h00, Z64, 1'b0, 1'b0, Z64,
                 1'b0, 1'b0, Z64, 1'b1, 1'b0, 3'd3, FA,  8'h00, Z64, 1'b1};
    vecs[2]  = '{"fetch done",  1'b1, FA,  1'b0, Z64, 3'd0, 8'h00, Z64, 1'b1, 1'b1, 64'h13,
                 1'b1, 1'b0, 64'h13, 1'b0, 1'b0, 3'd0, Z64, 8'h00, Z64, 1'b0};
    vecs[3]  = '{"idle1",       1'b0, Z64, 1'b0, Z64, 3'd0, 8'h00, Z64, 1'b0, 1'b0, Z64,
                 1'b0, 1'b0, Z64, 1'b0, 1'b0, 3'd0, Z64, 8'h00, Z64, 1'b0};
    vecs[4]  = '{"store grant", 1'b0, Z64, 1'b1, SA,  3'd4, 8'hFF, SD,  1'b0, 1'b0, Z64,
                 1'b0, 1'b0, Z64, 1'b1, 1'b1, 3'd4, SA,  8'hFF, SD,  1'b1};
    vecs[5]  = '{"store beat1", 1'b0, Z64, 1'b1, SA,  3'd4, 8'hFF, SD,  1'b1, 1'b0, 64'hAA,
                 1'b0, 1'b0, Z64, 1'b1, 1'b1, 3'd4, SA,  8'hFF, SD,  1'b1};
    vecs[6]  = '{"store beat2", 1'b0, Z64, 1'b1, SA,  3'd4, 8'hFF, SD,  1'b1, 1'b0, 64'hBB,
                 1'b0, 1'b0, Z64, 1'b1, 1'b1, 3'd4, SA,  8'hFF, SD,  1'b1};
    vecs[7]  = '{"store beat3", 1'b0, Z64, 1'b1, SA,  3'd4, 8'hFF, SD,  1'b1, 1'b0, 64'hCC,
                 1'b0, 1'b0, Z64, 1'b1, 1'b1, 3'd4, SA,  8'hFF, SD,  1'b1};
    vecs[8]  = '{"store done",  1'b0, Z64, 1'b1, SA,  3'd4, 8'hFF, SD,  1'b1, 1'b1, 64'h55,
                 1'b0, 1'b1, 64'h55, 1'b0, 1'b0, 3'd0, Z64, 8'h00, Z64, 1'b0};
    vecs[9]  = '{"idle2",       1'b0, Z64, 1'b0, Z64, 3'd0, 8'h00, Z64, 1'b0, 1'b0, Z64,
                 1'b0, 1'b0, Z64, 1'b0, 1'b0, 3'd0, Z64, 8'h00, Z64, 1'b0};
    vecs[10] = '{"drop req",    1'b1, DA,  1'b0, Z64, 3'd0, 8'h00, Z64, 1'b0, 1'b0, Z64,
                 1'b0, 1'b0, Z64, 1'b1, 1'b0, 3'd3, DA,  8'h00, Z64, 1'b1};
    vecs[11] = '{"drop hold",   1'b0, Z64, 1'b0, Z64, 3'd0, 8'h00, Z64, 1'b0, 1'b0, Z64,
                 1'b0, 1'b0, Z64, 1'b1, 1'b0, 3'd3, DA,  8'h00, Z64, 1'b1};
    vecs[12] = '{"drop done",   1'b0, Z64, 1'b0, Z64, 3'd0, 8'h00, Z64, 1'b1, 1'b1, 64'h77,
                 1'b1, 1'b0, 64'h77, 1'b0, 1'b0, 3'd0, Z64, 8'h00, Z64, 1'b0};

    reset = 1'b0;
    clearInputs();
    cycle();
    cycle();
    checkOutput("reset/cValid", 64'(bus.c_valid), 64'h0);
    checkOutput("reset/cAddr", bus.c_addr, 64'h0);
    checkOutput("reset/busy", 64'(busy), 64'h0);
    checkOutput("reset/timeout", 64'(timeoutErr), 64'h0);
    checkOutput("reset/iOk", 64'(bus.i_data_ok), 64'h0);
    checkOutput("reset/dOk", 64'(bus.d_data_ok), 64'h0);
    reset = 1'b1;
    cycle();

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("%s/iOk", vecs[i].name), 64'(bus.i_data_ok), 64'(vecs[i].expIOk));
      checkOutput($sformatf("%s/dOk", vecs[i].name), 64'(bus.d_data_ok), 64'(vecs[i].expDOk));
      if (vecs[i].expIOk) checkOutput($sformatf("%s/iRdata", vecs[i].name), bus.i_rdata, vecs[i].expRdata);
      if (vecs[i].expDOk) checkOutput($sformatf("%s/dRdata", vecs[i].name), bus.d_rdata, vecs[i].expRdata);
      cycle();
      checkOutput($sformatf("%s/cValid", vecs[i].name), 64'(bus.c_valid), 64'(vecs[i].expCValid));
      checkOutput($sformatf("%s/cIsWrite", vecs[i].name), 64'(bus.c_is_write), 64'(vecs[i].expCIsWrite));
      checkOutput($sformatf("%s/cSize", vecs[i].name), 64'(bus.c_size), 64'(vecs[i].expCSize));
      checkOutput($sformatf("%s/cAddr", vecs[i].name), bus.c_addr, vecs[i].expCAddr);
      checkOutput($sformatf("%s/cStrobe", vecs[i].name), 64'(bus.c_strobe), 64'(vecs[i].expCStrobe));
      checkOutput($sformatf("%s/cWdata", vecs[i].name), bus.c_wdata, vecs[i].expCWdata);
      checkOutput($sformatf("%s/busy", vecs[i].name), 64'(busy), 64'(vecs[i].expBusy));
    end
    clearInputs();

    // Contention from reset: both requesters rise together.
    doReset();
    cycle();
`ifdef ARB_RR_EN
    firstAddr = 64'h2000; secondAddr = 64'h3000; firstIsD = 1'b0;
`else
    firstAddr = 64'h3000; secondAddr = 64'h2000; firstIsD = 1'b1;
`endif
    bus.i_valid = 1'b1; bus.i_addr = 64'h2000;
    bus.d_valid = 1'b1; bus.d_addr = 64'h3000; bus.d_size = 3'd3; bus.d_strobe = 8'h00;
    cycle();
    checkOutput("cont/firstAddr", bus.c_addr, firstAddr);
    checkOutput("cont/firstValid", 64'(bus.c_valid), 64'h1);
    bus.c_ready = 1'b1; bus.c_last = 1'b1; bus.c_rdata = 64'h99;
    #1;
    checkOutput("cont/firstIOk", 64'(bus.i_data_ok), 64'(!firstIsD));
    checkOutput("cont/firstDOk", 64'(bus.d_data_ok), 64'(firstIsD));
    cycle();
    checkOutput("cont/gapBusy", 64'(busy), 64'h0);
    checkOutput("cont/gapValid", 64'(bus.c_valid), 64'h0);
    if (firstIsD) bus.d_valid = 1'b0;
    else          bus.i_valid = 1'b0;
    bus.c_ready = 1'b0; bus.c_last = 1'b0;
    cycle();
    checkOutput("cont/secondAddr", bus.c_addr, secondAddr);
    checkOutput("cont/secondBusy", 64'(busy), 64'h1);
    bus.c_ready = 1'b1; bus.c_last = 1'b1;
    #1;
    checkOutput("cont/secondIOk", 64'(bus.i_data_ok), 64'(firstIsD));
    checkOutput("cont/secondDOk", 64'(bus.d_data_ok), 64'(!firstIsD));
    cycle();
    clearInputs();
    checkOutput("cont/endBusy", 64'(busy), 64'h0);

    // Watchdog: memory stays silent past TIMEOUT=8 serve cycles.
    doReset();
    cycle();
    bus.i_valid = 1'b1; bus.i_addr = 64'h4000;
    cycle();
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (k == 7) checkOutput("wd/beforeExpiry", 64'(timeoutErr), 64'h0);
      if (k == 8) checkOutput("wd/atExpiry", 64'(timeoutErr), 64'h1);
    end
    checkOutput("wd/stillBusy", 64'(busy), 64'h1);
    checkOutput("wd/addrHeld", bus.c_addr, 64'h4000);
    for (int k = 0; k < 3; k++) cycle();
    checkOutput("wd/sticky", 64'(timeoutErr), 64'h1);
    bus.c_ready = 1'b1; bus.c_last = 1'b1; bus.c_rdata = 64'h42;
    #1;
    checkOutput("wd/lateOk", 64'(bus.i_data_ok), 64'h1);
    cycle();
    clearInputs();
    checkOutput("wd/lateIdle", 64'(busy), 64'h0);
    checkOutput("wd/afterDone", 64'(timeoutErr), 64'h1);
    doReset();
    cycle();

    // Asynchronous reset in the middle of a store.
    bus.d_valid = 1'b1; bus.d_addr = SA; bus.d_size = 3'd4; bus.d_strobe = 8'hFF; bus.d_wdata = SD;
    cycle();
    checkOutput("arst/granted", 64'(bus.c_valid), 64'h1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst/cValid", 64'(bus.c_valid), 64'h0);
    checkOutput("arst/busy", 64'(busy), 64'h0);
    checkOutput("arst/cAddr", bus.c_addr, 64'h0);
    clearInputs();
    bus.i_valid = 1'b1; bus.i_addr = 64'h5000;
    #1;
    reset = 1'b1;
    cycle();
    checkOutput("arst/regrantValid", 64'(bus.c_valid), 64'h1);
    checkOutput("arst/regrantAddr", bus.c_addr, 64'h5000);
    checkOutput("arst/regrantSize", 64'(bus.c_size), 64'h3);
    bus.c_ready = 1'b1; bus.c_last = 1'b1;
    cycle();
    clearInputs();
    checkOutput("arst/finalIdle", 64'(busy), 64'h0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
